// File: rtl/alu_pkg.sv
// Shared definitions for the ALU sequencer: widths, op codes, FSM encoding
// and the captured-request payload.
package alu_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned MUL_W  = 16;
    localparam int unsigned SEL_W  = 3;

    localparam logic [SEL_W-1:0] OP_AND = 3'b000;
    localparam logic [SEL_W-1:0] OP_OR  = 3'b001;
    localparam logic [SEL_W-1:0] OP_ADD = 3'b010;
    localparam logic [SEL_W-1:0] OP_SLL = 3'b011;
    localparam logic [SEL_W-1:0] OP_MUL = 3'b100;
    localparam logic [SEL_W-1:0] OP_SRL = 3'b101;
    localparam logic [SEL_W-1:0] OP_SUB = 3'b110;
    localparam logic [SEL_W-1:0] OP_SLT = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_MUL  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    typedef struct packed {
        logic [SEL_W-1:0]  sel;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
    } op_req_t;

endpackage

// File: rtl/alu.sv
// Existing combinational 32-bit ALU (MUL code is unimplemented and yields 0).
// Ports: a, b operands; ALU_sel op code; ALU_result result; OF signed
// overflow for ADD/SUB.
module alu
    import alu_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [SEL_W-1:0]  ALU_sel,
    output logic [DATA_W-1:0] ALU_result,
    output logic              OF
);

    logic [DATA_W-1:0] sum;
    logic [DATA_W-1:0] diff;

    assign sum  = a + b;
    assign diff = a - b;

    // Operation select; overflow only meaningful for the signed add/sub.
    always_comb begin
        ALU_result = '0;
        OF         = 1'b0;
        case (ALU_sel)
            OP_AND: ALU_result = a & b;
            OP_OR:  ALU_result = a | b;
            OP_ADD: begin
                ALU_result = sum;
                OF         = (a[DATA_W-1] == b[DATA_W-1]) && (sum[DATA_W-1] != a[DATA_W-1]);
            end
            OP_SLL: ALU_result = a << b[4:0];
            OP_SRL: ALU_result = a >> b[4:0];
            OP_SUB: begin
                ALU_result = diff;
                OF         = (a[DATA_W-1] != b[DATA_W-1]) && (diff[DATA_W-1] != a[DATA_W-1]);
            end
            OP_SLT: ALU_result = ($signed(a) < $signed(b)) ? DATA_W'(1) : '0;
            default: ALU_result = '0;
        endcase
    end

endmodule

// File: rtl/alu_seq_ctrl_booth.sv
// Iterative radix-2 Booth multiplier, one step per enabled edge.
// Ports: clk, rst (async active-high); load initialises acc/mq/q_1/cnt from
// mplier; step performs one Booth step using mcand; done and product are
// combinational look-ahead: done flags the final step, product is the
// post-shift {acc,mq} of the current step.
module booth_mul_iter
    import alu_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic                 step,
    input  logic [MUL_W-1:0]     mcand,
    input  logic [MUL_W-1:0]     mplier,
    output logic                 done,
    output logic [2*MUL_W-1:0]   product
);

    localparam int unsigned ACC_W = MUL_W + 1;
    localparam int unsigned CNT_W = $clog2(MUL_W);

    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] acc_sum;
    logic [ACC_W-1:0] acc_nxt;
    logic [ACC_W-1:0] m;
    logic [MUL_W-1:0] mq;
    logic [MUL_W-1:0] mq_nxt;
    logic             q_1;
    logic [CNT_W-1:0] cnt;

    // 17-bit accumulator keeps -M representable when mcand is the most negative value.
    assign m = {mcand[MUL_W-1], mcand};

    // Booth add/subtract followed by arithmetic right shift of {acc,mq,q_1}.
    always_comb begin
        acc_sum = acc;
        case ({mq[0], q_1})
            2'b01:   acc_sum = acc + m;
            2'b10:   acc_sum = acc - m;
            default: acc_sum = acc;
        endcase
        acc_nxt = {acc_sum[ACC_W-1], acc_sum[ACC_W-1:1]};
        mq_nxt  = {acc_sum[0], mq[MUL_W-1:1]};
    end

    assign done    = step && (cnt == CNT_W'(MUL_W - 1));
    assign product = {acc_nxt[MUL_W-1:0], mq_nxt};

    // Iteration state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc <= '0;
            mq  <= '0;
            q_1 <= 1'b0;
            cnt <= '0;
        end else if (load) begin
            acc <= '0;
            mq  <= mplier;
            q_1 <= 1'b0;
            cnt <= '0;
        end else if (step) begin
            acc <= acc_nxt;
            mq  <= mq_nxt;
            q_1 <= mq[0];
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/alu_seq_ctrl.sv
// Operation sequencer around the combinational ALU: one request at a time,
// MUL on the iterative Booth unit, one registered response per request.
// Ports: clk, rst (async active-high); req_valid/req_ready/req_sel/req_a/
// req_b request channel; rsp_valid/rsp_ready/rsp_result/rsp_of response
// channel; busy while an op is in flight.
module alu_seq_ctrl
    import alu_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [SEL_W-1:0]  req_sel,
    input  logic [DATA_W-1:0] req_a,
    input  logic [DATA_W-1:0] req_b,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_result,
    output logic              rsp_of,
    output logic              busy
);

    state_t               state;
    state_t               state_nxt;
    op_req_t              op;
    logic                 accept;
    logic                 mul_load;
    logic                 mul_step;
    logic                 exec_cap;
    logic                 mul_cap;
    logic [DATA_W-1:0]    alu_result;
    logic                 alu_of;
    logic                 mul_done;
    logic [2*MUL_W-1:0]   mul_product;

    alu u_alu (
        .a          (op.a),
        .b          (op.b),
        .ALU_sel    (op.sel),
        .ALU_result (alu_result),
        .OF         (alu_of)
    );

    // Multiplier is loaded straight from the request so stepping starts next edge.
    booth_mul_iter u_mul (
        .clk     (clk),
        .rst     (rst),
        .load    (mul_load),
        .step    (mul_step),
        .mcand   (op.a[MUL_W-1:0]),
        .mplier  (req_b[MUL_W-1:0]),
        .done    (mul_done),
        .product (mul_product)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and control strobes.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        mul_load  = 1'b0;
        mul_step  = 1'b0;
        exec_cap  = 1'b0;
        mul_cap   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (req_valid && req_ready) begin
                    accept = 1'b1;
                    if (req_sel == OP_MUL) begin
                        mul_load  = 1'b1;
                        state_nxt = ST_MUL;
                    end else begin
                        state_nxt = ST_EXEC;
                    end
                end
            end
            ST_EXEC: begin
                exec_cap  = 1'b1;
                state_nxt = ST_DONE;
            end
            ST_MUL: begin
                mul_step = 1'b1;
                if (mul_done) begin
                    mul_cap   = 1'b1;
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                if (rsp_ready) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Captured operands, response registers and handshake outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op         <= '0;
            rsp_result <= '0;
            rsp_of     <= 1'b0;
            rsp_valid  <= 1'b0;
            req_ready  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            req_ready <= (state_nxt == ST_IDLE);
            rsp_valid <= (state_nxt == ST_DONE);
            busy      <= (state_nxt != ST_IDLE);
            if (accept) begin
                op <= op_req_t'{sel: req_sel, a: req_a, b: req_b};
            end
            if (exec_cap) begin
                rsp_result <= alu_result;
                rsp_of     <= alu_of && ((op.sel == OP_ADD) || (op.sel == OP_SUB));
            end else if (mul_cap) begin
                rsp_result <= DATA_W'(mul_product);
                rsp_of     <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed self-checking bench for alu_seq_ctrl.
module tb_alu_seq_ctrl;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_sel;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_result;
    logic        rsp_of;
    logic        busy;

    int n_tests = 0;
    int n_fail  = 0;

    alu_seq_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_sel    (req_sel),
        .req_a      (req_a),
        .req_b      (req_b),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_of     (rsp_of),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one op with rsp_ready high; lat = edges after the accept edge until rsp_valid.
    task automatic run_op(input string tag, input logic [2:0] sel, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_res,
                          input logic exp_of, input int lat);
        check({tag, "_ready_in"}, 32'(req_ready), 32'd1);
        req_sel   = sel;
        req_a     = a;
        req_b     = b;
        req_valid = 1'b1;
        rsp_ready = 1'b1;
        tick();
        req_valid = 1'b0;
        req_a     = 32'h0;
        req_b     = 32'h0;
        for (int i = 0; i < lat; i++) begin
            check({tag, "_valid_low"}, 32'(rsp_valid), 32'd0);
            check({tag, "_busy"}, 32'(busy), 32'd1);
            tick();
        end
        check({tag, "_valid"}, 32'(rsp_valid), 32'd1);
        check({tag, "_result"}, rsp_result, exp_res);
        check({tag, "_of"}, 32'(rsp_of), 32'(exp_of));
        tick();
        check({tag, "_valid_drop"}, 32'(rsp_valid), 32'd0);
        check({tag, "_ready_back"}, 32'(req_ready), 32'd1);
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = 1'b0;
        req_sel   = 3'b000;
        req_a     = 32'h0;
        req_b     = 32'h0;
        rsp_ready = 1'b0;

        // Reset state
        tick();
        tick();
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_result", rsp_result, 32'h0);
        check("rst_of", 32'(rsp_of), 32'd0);
        rst = 1'b0;
        tick();
        check("post_rst_ready", 32'(req_ready), 32'd1);

        // ALU ops: overflow, flag clears, signed compare
        run_op("add_of", 3'b010, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b1, 1);
        run_op("and", 3'b000, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b0, 1);
        run_op("slt", 3'b111, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, 1'b0, 1);

        // Booth multiply: small signed product and most-negative squared with junk upper halves
        run_op("mul_neg", 3'b100, 32'h0000_0003, 32'hFFFF_FFFB, 32'hFFFF_FFF1, 1'b0, 16);
        run_op("mul_min", 3'b100, 32'hABCD_8000, 32'h1234_8000, 32'h4000_0000, 1'b0, 16);

        // Backpressure in DONE with a competing request present
        rsp_ready = 1'b0;
        req_sel   = 3'b001;
        req_a     = 32'h0000_00F0;
        req_b     = 32'h0000_000F;
        req_valid = 1'b1;
        tick();
        req_sel = 3'b011;
        req_a   = 32'h0000_0001;
        req_b   = 32'h0000_0004;
        tick();
        for (int i = 0; i < 5; i++) begin
            check("hold_valid", 32'(rsp_valid), 32'd1);
            check("hold_ready", 32'(req_ready), 32'd0);
            check("hold_result", rsp_result, 32'h0000_00FF);
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        check("release_valid", 32'(rsp_valid), 32'd0);
        check("release_ready", 32'(req_ready), 32'd1);
        check("release_busy", 32'(busy), 32'd0);
        tick();
        req_valid = 1'b0;
        check("next_accept_busy", 32'(busy), 32'd1);
        check("next_accept_ready", 32'(req_ready), 32'd0);
        tick();
        check("next_valid", 32'(rsp_valid), 32'd1);
        check("next_result", rsp_result, 32'h0000_0010);
        tick();
        check("next_idle", 32'(req_ready), 32'd1);

        // Reset during MUL step 8
        req_sel   = 3'b100;
        req_a     = 32'h0000_0003;
        req_b     = 32'h0000_0005;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        check("mid_mul_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        check("arst_valid", 32'(rsp_valid), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_result", rsp_result, 32'h0);
        check("arst_ready", 32'(req_ready), 32'd0);
        tick();
        rst = 1'b0;
        tick();
        check("arst_ready_back", 32'(req_ready), 32'd1);
        run_op("sub_after_rst", 3'b110, 32'h0000_0005, 32'h0000_0007, 32'hFFFF_FFFE, 1'b0, 1);
        for (int i = 0; i < 17; i++) tick();
        check("no_stale_valid", 32'(rsp_valid), 32'd0);
        check("no_stale_busy", 32'(busy), 32'd0);
        check("no_stale_result", rsp_result, 32'hFFFF_FFFE);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_seq_ctrl.md
Name: alu_seq_ctrl

Overview:
- Operation sequencer wrapped around the existing 32-bit `alu`.
- Accepts one operation at a time over a valid/ready request channel. Non-multiply ops go through the combinational `alu`. ALU_sel=100 (MUL, unimplemented in `alu`) runs on an internal 16-step radix-2 Booth multiplier.
- Returns one registered result per request over a valid/ready response channel. Sits between the issue/decode logic and the `alu` instance.

Parameters:
- DATA_W, 32, operand/result width; only 32 is supported.
- MUL_W, 16, multiplier operand width; also the Booth step count.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept a request.
- req_sel  in  3  op code, same encoding as `alu` ALU_sel.
- req_a  in  32  operand A.
- req_b  in  32  operand B.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer takes result.
- rsp_result  out  32  operation result.
- rsp_of  out  1  overflow flag.
- busy  out  1  op in flight (state != IDLE).

Behaviour:
- Interface: one clock (clk); reset rst is asynchronous and active-high.
- Reset: state=IDLE. req_ready=1 after reset release; while rst is high req_ready=0. rsp_valid=0, rsp_result=0, rsp_of=0, busy=0. All internal registers cleared.
- States: IDLE, EXEC, MUL, DONE.
- IDLE:
  - req_ready=1.
  - On req_valid at an edge: capture sel/a/b into op registers.
  - Next state is MUL if sel==100, else EXEC.
  - For MUL, also load the accumulator: acc=0 (17 bits), mq=req_b[15:0], q_1=0, cnt=0.
- EXEC (1 cycle):
  - `alu` is driven from the captured operands.
  - At the edge: rsp_result<=ALU_result. rsp_of<=OF when sel is 010 or 110, else 0. State goes to DONE.
  - The result is therefore valid 2 edges after the accept edge.
- MUL (16 cycles, one Booth step per edge; M = sign-extended A[15:0] to 17 bits):
  - {mq[0],q_1}=01: acc+=M.
  - {mq[0],q_1}=10: acc-=M.
  - Otherwise acc unchanged.
  - Then arithmetic right shift of {acc,mq,q_1} by 1, and cnt+=1.
  - When cnt==15 at the edge: rsp_result<={acc,mq}[31:0] from the post-shift value, rsp_of<=0, state goes to DONE.
  - Result is the signed 16x16 product, exact in 32 bits. A[31:16] and B[31:16] are ignored.
- DONE:
  - rsp_valid=1; rsp_result and rsp_of are held stable.
  - req_ready=0.
  - On rsp_ready at an edge: state goes to IDLE and rsp_valid drops. No same-edge accept of a new request.
- Throughput: non-MUL ops 1 per 3 cycles; MUL 1 per 18 cycles (with rsp_ready held high).
- req_valid outside IDLE is ignored. Request signals need not be held after acceptance.
- rsp_result and rsp_of change only on entry to DONE or on reset.
- Reset mid-operation (any state): immediate return to reset values. The in-flight op is discarded with no response.
- busy=1 in EXEC, MUL and DONE.

Decomposition:
- Shared package `alu_pkg`:
  - op code constants OP_AND=000, OP_OR=001, OP_ADD=010, OP_SLL=011, OP_MUL=100, OP_SRL=101, OP_SUB=110, OP_SLT=111.
  - state encoding.
  - MUL_W.
- Sub-module `booth_mul_iter`:
  - holds acc/mq/q_1/cnt; ports load, step, done, product.
  - controlled by the alu_seq_ctrl FSM.
- `alu` is instantiated unchanged, with ALU_sel forced to the captured sel.

Test Plan:
- ADD a=0x7FFFFFFF, b=1 → rsp_valid rises 2 edges after accept; result=0x80000000, rsp_of=1.
- AND a=0xF0F0F0F0, b=0xFF00FF00 → result=0xF000F000, rsp_of=0. Then SLT a=0xFFFFFFFF (-1), b=0 → result=1.
- MUL a=0x00000003, b=0xFFFFFFFB → result=0xFFFFFFF1 (-15), rsp_valid 17 edges after accept, busy=1 throughout, rsp_of=0.
- MUL a=0xABCD8000, b=0x12348000 → result=0x40000000; the upper operand halves are proven ignored (-32768 squared).
- Hold rsp_ready=0 for 5 cycles in DONE with req_valid=1 → result stable, req_ready=0, no capture. Raise rsp_ready → IDLE next edge, then the next request is accepted.
- Assert rst during MUL step 8 → rsp_valid/busy/rsp_result=0 immediately. After release, a SUB a=5, b=7 returns 0xFFFFFFFE with no stale MUL response.
